// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
package fetch_pkg;

  localparam int INSTR_WIDTH = 32;
  // Width of the PC stored alongside each buffered instruction.
  // The fetch unit supports address widths up to this value.
  localparam int PC_WIDTH    = 32;
  localparam int PC_INCR     = 4;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order instruction buffer of fetch_entry_t.
// Synchronous flush, and flush wins over a same-cycle push.
// A push and a pop in the same cycle are allowed even when full.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues word reads to instruction memory,
// buffers returned words in order and hands them to decode.
// Optional performance counters: define INSTR_FETCH_PERF_EN.
//
// Handshakes: a transfer happens in a cycle where valid && ready are both
// high. Request valid never depends on imem_req_ready, and the address is
// held while valid && !ready. Responses have no ready and are always taken.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [ADDR_WIDTH-1:0]  imem_req_addr,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  instr_pc
`ifdef INSTR_FETCH_PERF_EN
  ,
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_dropped,
  output logic [15:0]            perf_redirects
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]         CNT_ONE    = 1;
  localparam logic [CW:0]           CREDIT_MAX = (CW+1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(PC_INCR);

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] rsp_pc;
  logic [ADDR_WIDTH-1:0] redirect_target;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         drop_cnt;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           credit_used;
  logic                  req_fire;
  logic                  rsp_drop;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_empty;
  fetch_entry_t          push_entry;
  fetch_entry_t          head_entry;
  fetch_entry_t          last_entry;

  // Requests in flight plus buffered entries never exceed the buffer size,
  // so every response is guaranteed a slot.
  assign credit_used     = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req_valid  = !rst && !redirect_valid && (credit_used < CREDIT_MAX);
  assign imem_req_addr   = fetch_pc;
  assign req_fire        = imem_req_valid && imem_req_ready;
  assign redirect_target = redirect_pc & ~ADDR_WIDTH'(2'b11);

  // Wrong-path words: anything arriving with a redirect, or while drops remain.
  assign rsp_drop   = imem_rsp_valid && (redirect_valid || (drop_cnt != '0));
  assign fifo_push  = imem_rsp_valid && !rsp_drop;
  assign push_entry = '{instr: imem_rsp_data, pc: PC_WIDTH'(rsp_pc)};

  assign fifo_empty  = (fifo_count == '0);
  assign instr_valid = !rst && !redirect_valid && !fifo_empty;
  assign fifo_pop    = instr_valid && instr_ready;
  // When empty, the last delivered instruction stays on the outputs.
  assign instr       = fifo_empty ? last_entry.instr : head_entry.instr;
  assign instr_pc    = ADDR_WIDTH'(fifo_empty ? last_entry.pc : head_entry.pc);

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .push     (fifo_push),
    .push_data(push_entry),
    .pop      (fifo_pop),
    .head     (head_entry),
    .count    (fifo_count)
  );

  // PC tracking, in-flight count and wrong-path drop count.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      case ({req_fire, imem_rsp_valid})
        2'b10:   outstanding <= outstanding + CNT_ONE;
        2'b01:   outstanding <= outstanding - CNT_ONE;
        default: ;
      endcase
      if (redirect_valid) begin
        fetch_pc <= redirect_target;
        rsp_pc   <= redirect_target;
        // Everything still in flight after this cycle belongs to the old path.
        drop_cnt <= imem_rsp_valid ? outstanding - CNT_ONE : outstanding;
      end else begin
        if (req_fire)  fetch_pc <= fetch_pc + PC_STEP;
        if (fifo_push) rsp_pc   <= rsp_pc + PC_STEP;
        if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CNT_ONE;
      end
    end
  end

  // Hold the most recently delivered instruction for the empty case.
  always_ff @(posedge clk) begin
    if (rst)           last_entry <= '0;
    else if (fifo_pop) last_entry <= head_entry;
  end

`ifdef INSTR_FETCH_PERF_EN
  logic [31:0] dropped_inc;
  logic [32:0] fetched_sum;
  logic [32:0] dropped_sum;
  logic [16:0] redirect_sum;

  assign dropped_inc  = (redirect_valid ? 32'(fifo_count) : 32'd0) + (rsp_drop ? 32'd1 : 32'd0);
  assign fetched_sum  = {1'b0, perf_fetched} + 33'(fifo_pop);
  assign dropped_sum  = {1'b0, perf_dropped} + {1'b0, dropped_inc};
  assign redirect_sum = {1'b0, perf_redirects} + 17'(redirect_valid);

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched   <= '0;
      perf_dropped   <= '0;
      perf_redirects <= '0;
    end else begin
      perf_fetched   <= fetched_sum[32]   ? '1 : fetched_sum[31:0];
      perf_dropped   <= dropped_sum[32]   ? '1 : dropped_sum[31:0];
      perf_redirects <= redirect_sum[16]  ? '1 : redirect_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized phase,
// checked every cycle against a behavioural model of the fetch stream.
module tb_instr_fetch_unit;

  localparam int          AW       = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
`ifdef INSTR_FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_dropped;
  logic [15:0] perf_redirects;
`endif

  instr_fetch_unit #(
    .ADDR_WIDTH(AW),
    .RESET_PC  (RESET_PC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc)
`ifdef INSTR_FETCH_PERF_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_dropped  (perf_dropped),
    .perf_redirects(perf_redirects)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  int n_cmp;
  int n_fail;
  int cyc;
  int lat;
  int rsp_pct;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;
  mem_req_t mq[$];          // memory: accepted requests awaiting a response

  logic [31:0] exp_q[$];    // scoreboard: PCs of words the stage should be holding
  logic [31:0] pop_log[$];  // PCs delivered to decode, for directed checks

  logic [31:0] m_fetch_pc;
  logic [31:0] m_rsp_pc;
  logic [31:0] m_last_instr;
  logic [31:0] m_last_pc;
  int          m_drop;
  int          m_pops;
  int          m_dropped;
  int          m_redirs;
  logic        obs_fire;
  logic [31:0] obs_addr;

  // Memory content: an odd multiply is a bijection, so each address has a distinct word.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_fetch_pc   = RESET_PC;
    m_rsp_pc     = RESET_PC;
    exp_q.delete();
    m_drop       = 0;
    m_last_instr = 32'h0;
    m_last_pc    = 32'h0;
    m_pops       = 0;
    m_dropped    = 0;
    m_redirs     = 0;
  endtask

  // ---------------- driver tasks ----------------
  // Memory drives a response for the oldest request once its latency has elapsed.
  task automatic drive_mem();
    if (!rst && mq.size() > 0 && mq[0].due <= cyc && $urandom_range(0, 99) < rsp_pct) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_of(mq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  // Mid-cycle: compare outputs with the model, then advance the model.
  task automatic sample_and_model();
    logic exp_rv;
    logic exp_iv;
    logic pop;
    obs_fire = imem_req_valid && imem_req_ready;
    obs_addr = imem_req_addr;
    if (rst) begin
      check("rst_req_valid", 32'(imem_req_valid), 32'h0);
      model_reset();
      return;
    end
    exp_rv = !redirect_valid && (mq.size() + exp_q.size() < DEPTH);
    exp_iv = !redirect_valid && (exp_q.size() > 0);
    check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    check("req_addr", imem_req_addr, m_fetch_pc);
    check("instr_valid", 32'(instr_valid), 32'(exp_iv));
    if (exp_q.size() == 0) begin
      check("hold_instr", instr, m_last_instr);
      check("hold_instr_pc", instr_pc, m_last_pc);
    end
    pop = exp_iv && instr_ready;
    if (pop) begin
      check("instr_pc", instr_pc, exp_q[0]);
      check("instr", instr, word_of(exp_q[0]));
      m_last_pc    = exp_q[0];
      m_last_instr = word_of(exp_q[0]);
      pop_log.push_back(exp_q[0]);
      void'(exp_q.pop_front());
      m_pops++;
    end
    if (redirect_valid) begin
      m_dropped += exp_q.size();
      exp_q.delete();
      m_drop = mq.size() - (imem_rsp_valid ? 1 : 0);
      if (imem_rsp_valid) m_dropped++;
      m_fetch_pc = {redirect_pc[31:2], 2'b00};
      m_rsp_pc   = {redirect_pc[31:2], 2'b00};
      m_redirs++;
    end else begin
      if (imem_rsp_valid) begin
        if (m_drop > 0) begin
          m_drop--;
          m_dropped++;
        end else begin
          exp_q.push_back(m_rsp_pc);
          m_rsp_pc = m_rsp_pc + 32'd4;
        end
      end
      if (exp_rv && imem_req_ready) m_fetch_pc = m_fetch_pc + 32'd4;
    end
  endtask

  // After the edge: memory retires the delivered response and records a new request.
  task automatic mem_commit();
    if (rst) mq.delete();
    else begin
      if (imem_rsp_valid) void'(mq.pop_front());
      if (obs_fire) mq.push_back('{addr: obs_addr, due: cyc + lat});
    end
    cyc++;
  endtask

  task automatic cycle();
    @(negedge clk);
    sample_and_model();
    @(posedge clk);
    #1;
    mem_commit();
  endtask

  task automatic tick();
    drive_mem();
    cycle();
  endtask

  task automatic run_rand(input int n, input int rr_pct, input int ir_pct, input int rd_pct);
    for (int i = 0; i < n; i++) begin
      imem_req_ready = ($urandom_range(0, 99) < rr_pct);
      instr_ready    = ($urandom_range(0, 99) < ir_pct);
      redirect_pc    = $urandom;
      redirect_valid = ($urandom_range(0, 99) < rd_pct);
      tick();
    end
    redirect_valid = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int found;
    n_cmp = 0; n_fail = 0; cyc = 0; lat = 1; rsp_pct = 100;
    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    model_reset();
    @(posedge clk); #1;
    tick(); tick();

    // Reset release: registered reset values, then stream from RESET_PC.
    rst = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b1;
    #1;
    check("reset_instr_valid", 32'(instr_valid), 32'h0);
    check("reset_req_addr", imem_req_addr, RESET_PC);
    check("reset_instr", instr, 32'h0);
    check("reset_instr_pc", instr_pc, 32'h0);
    check("reset_req_valid", 32'(imem_req_valid), 32'h1);
    pop_log.delete();
    tick(); tick();
    #1;
    check("first_instr_valid", 32'(instr_valid), 32'h1);
    check("first_instr_pc", instr_pc, RESET_PC);
    repeat (18) tick();
    check("throughput_pops", 32'(pop_log.size()), 32'd18);

    // Decode stall: credit runs out, request valid drops, nothing lost.
    instr_ready = 1'b0;
    repeat (10) tick();
    check("stall_req_valid", 32'(imem_req_valid), 32'h0);
    check("stall_instr_valid", 32'(instr_valid), 32'h1);
    instr_ready = 1'b1;
    repeat (10) tick();

    // Memory stall: address held at 0x10 until accepted.
    redirect_valid = 1'b1; redirect_pc = 32'h8;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 10 && m_fetch_pc != 32'h10; i++) tick();
    check("mstall_setup_addr", imem_req_addr, 32'h10);
    imem_req_ready = 1'b0;
    repeat (3) begin
      tick();
      check("mstall_addr_hold", imem_req_addr, 32'h10);
      check("mstall_valid_hold", 32'(imem_req_valid), 32'h1);
    end
    imem_req_ready = 1'b1;
    tick();
    check("mstall_addr_advance", imem_req_addr, 32'h14);

    // Redirect to 0x100 with two in flight and two buffered.
    rst = 1'b1; tick(); rst = 1'b0;
    lat = 2; instr_ready = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (mq.size() == 2 && exp_q.size() == 2) found = 1;
      else tick();
    end
    check("redir_setup", 32'(found), 32'h1);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0; instr_ready = 1'b1;
    pop_log.delete();
    repeat (15) tick();
    check("redir_pops", 32'(pop_log.size() >= 2), 32'h1);
    check("redir_first_pc", pop_log[0], 32'h100);
    check("redir_second_pc", pop_log[1], 32'h104);

    // Redirect to 0x203 in the same cycle a response arrives.
    lat = 1;
    repeat (6) tick();
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      drive_mem();
      if (imem_rsp_valid) begin
        redirect_valid = 1'b1; redirect_pc = 32'h203; found = 1;
      end
      cycle();
      redirect_valid = 1'b0;
    end
    check("rsp_redir_setup", 32'(found), 32'h1);
    check("rsp_redir_addr", imem_req_addr, 32'h200);
    pop_log.delete();
    repeat (8) tick();
    check("rsp_redir_first_pc", pop_log[0], 32'h200);

    // Randomized traffic: memory latency/gaps, stalls on both sides, redirects.
    for (int b = 0; b < 6; b++) begin
      lat     = $urandom_range(1, 3);
      rsp_pct = $urandom_range(40, 100);
      run_rand(250, 70, 70, 3);
    end
    rsp_pct = 100; lat = 1;
    imem_req_ready = 1'b1; instr_ready = 1'b1;
    repeat (10) tick();

`ifdef INSTR_FETCH_PERF_EN
    check("perf_fetched", perf_fetched, 32'(m_pops));
    check("perf_dropped", perf_dropped, 32'(m_dropped));
    check("perf_redirects", 32'(perf_redirects), 32'(m_redirs));
`endif

    // Reset mid-stream with a non-empty buffer.
    instr_ready = 1'b0;
    repeat (3) tick();
    check("mid_rst_nonempty", 32'(instr_valid), 32'h1);
    rst = 1'b1; tick(); rst = 1'b0;
    instr_ready = 1'b1;
    #1;
    check("mid_rst_instr_valid", 32'(instr_valid), 32'h0);
    check("mid_rst_req_addr", imem_req_addr, RESET_PC);
`ifdef INSTR_FETCH_PERF_EN
    check("mid_rst_perf_fetched", perf_fetched, 32'h0);
    check("mid_rst_perf_dropped", perf_dropped, 32'h0);
    check("mid_rst_perf_redirects", 32'(perf_redirects), 32'h0);
`endif
    pop_log.delete();
    repeat (10) tick();
    check("mid_rst_restart_pc", pop_log[0], RESET_PC);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
